// File: rtl/ifns_tx_arbiter_21.sv
// Two-requester round-robin arbiter feeding one shared IFNS (21,15) encoder into a
// one-entry registered output slot with valid/ready handshake and a saturating delivery count.

module encoderIFNS_15di_core (
  input  logic [14:0] di,
  output logic        d1,
  output logic        d2,
  output logic        d3,
  output logic        d4,
  output logic        d5,
  output logic        d6,
  output logic        d7,
  output logic        d8,
  output logic        d9,
  output logic        d10,
  output logic        d11,
  output logic        d12,
  output logic        d13,
  output logic        d14,
  output logic        d15,
  output logic        d16,
  output logic        d17,
  output logic        d18,
  output logic        d19,
  output logic        d20,
  output logic        d21
);
  // Data sits at the non-power-of-two positions 1..20; d21 is overall parity.
  assign d3  = di[0];
  assign d5  = di[1];
  assign d6  = di[2];
  assign d7  = di[3];
  assign d9  = di[4];
  assign d10 = di[5];
  assign d11 = di[6];
  assign d12 = di[7];
  assign d13 = di[8];
  assign d14 = di[9];
  assign d15 = di[10];
  assign d17 = di[11];
  assign d18 = di[12];
  assign d19 = di[13];
  assign d20 = di[14];

  assign d1  = ^{di[0], di[1], di[3], di[4], di[6], di[8], di[10], di[11], di[13]};
  assign d2  = ^{di[0], di[2], di[3], di[5], di[6], di[9], di[10], di[12], di[13]};
  assign d4  = ^{di[1], di[2], di[3], di[7], di[8], di[9], di[10], di[14]};
  assign d8  = ^{di[4], di[5], di[6], di[7], di[8], di[9], di[10]};
  assign d16 = ^{di[11], di[12], di[13], di[14]};

  assign d21 = ^{d1, d2, d3, d4, d5, d6, d7, d8, d9, d10,
                 d11, d12, d13, d14, d15, d16, d17, d18, d19, d20};
endmodule

module ifns_tx_arbiter_21 #(
  parameter bit          HOLD_LAST = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [14:0]      req0_data,
  input  logic [14:0]      req1_data,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [21:1]      codeout,
  output logic             out_src,
  output logic [CNT_W-1:0] tx_count
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q;
  logic [21:1]      codeout_q;
  logic             out_src_q;
  logic             ptr_q;
  logic [CNT_W-1:0] tx_count_q;

  logic        slot_free;
  logic        win0;
  logic        win1;
  logic        accept;
  logic        deliver;
  logic [14:0] enc_in;
  logic [21:1] enc_out;

  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (ptr_q == 1'b0) begin
      win0 = req0_valid;
      win1 = !req0_valid && req1_valid;
    end else begin
      win1 = req1_valid;
      win0 = !req1_valid && req0_valid;
    end
  end

  assign slot_free  = (state_q == StEmpty) || out_ready;
  // Gate with rst_n so nothing is accepted while reset is held.
  assign req0_ready = rst_n && slot_free && win0;
  assign req1_ready = rst_n && slot_free && win1;
  assign accept     = req0_ready || req1_ready;
  assign deliver    = (state_q == StFull) && out_ready;
  assign enc_in     = win1 ? req1_data : req0_data;

  encoderIFNS_15di_core u_core (
    .di  (enc_in),
    .d1  (enc_out[1]),
    .d2  (enc_out[2]),
    .d3  (enc_out[3]),
    .d4  (enc_out[4]),
    .d5  (enc_out[5]),
    .d6  (enc_out[6]),
    .d7  (enc_out[7]),
    .d8  (enc_out[8]),
    .d9  (enc_out[9]),
    .d10 (enc_out[10]),
    .d11 (enc_out[11]),
    .d12 (enc_out[12]),
    .d13 (enc_out[13]),
    .d14 (enc_out[14]),
    .d15 (enc_out[15]),
    .d16 (enc_out[16]),
    .d17 (enc_out[17]),
    .d18 (enc_out[18]),
    .d19 (enc_out[19]),
    .d20 (enc_out[20]),
    .d21 (enc_out[21])
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      codeout_q  <= '0;
      out_src_q  <= 1'b0;
      ptr_q      <= 1'b0;
      tx_count_q <= '0;
    end else begin
      if (accept) begin
        state_q   <= StFull;
        codeout_q <= enc_out;
        out_src_q <= req1_ready;
        ptr_q     <= !req1_ready;
      end else if (deliver) begin
        state_q <= StEmpty;
        if (!HOLD_LAST) codeout_q <= '0;
      end
      if (deliver && (tx_count_q != {CNT_W{1'b1}})) begin
        tx_count_q <= tx_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_valid = (state_q == StFull);
  assign codeout   = codeout_q;
  assign out_src   = out_src_q;
  assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_ifns_tx_arbiter_21.sv
// Directed bench: one default instance (HOLD_LAST=1, 16-bit count) and one with
// HOLD_LAST=0 and a 4-bit count, both driven by the same stimulus.

module tb_ifns_tx_arbiter_21;

  logic        clock;
  logic        rst_n;
  logic        v0, v1;
  logic [14:0] d0, d1;
  logic        out_ready;

  logic        r0a, r1a, ova, srca;
  logic [21:1] cxa;
  logic [15:0] cnta;
  logic        r0b, r1b, ovb, srcb;
  logic [21:1] cxb;
  logic [3:0]  cntb;

  int n_chk;
  int n_fail;

  ifns_tx_arbiter_21 #(.HOLD_LAST(1'b1), .CNT_W(16)) dut_a (
    .clock(clock), .rst_n(rst_n),
    .req0_valid(v0), .req1_valid(v1), .req0_data(d0), .req1_data(d1),
    .req0_ready(r0a), .req1_ready(r1a),
    .out_valid(ova), .out_ready(out_ready), .codeout(cxa), .out_src(srca), .tx_count(cnta)
  );

  ifns_tx_arbiter_21 #(.HOLD_LAST(1'b0), .CNT_W(4)) dut_b (
    .clock(clock), .rst_n(rst_n),
    .req0_valid(v0), .req1_valid(v1), .req0_data(d0), .req1_data(d1),
    .req0_ready(r0b), .req1_ready(r1b),
    .out_valid(ovb), .out_ready(out_ready), .codeout(cxb), .out_src(srcb), .tx_count(cntb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Extended Hamming reference: place data, then derive each parity by position scan.
  function automatic logic [21:1] model(input logic [14:0] d);
    logic [20:1] c;
    int k;
    int p;
    logic par;
    c = '0;
    k = 0;
    for (int pos = 1; pos <= 20; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 5; j++) begin
      p = 1 << j;
      par = 1'b0;
      for (int pos = 1; pos <= 20; pos++) if ((pos & p) != 0) par = par ^ c[pos];
      c[p] = par;
    end
    return {^c, c};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v0 = 1'b1; v1 = 1'b0; d0 = '0; d1 = '0; out_ready = 1'b1;
    #2;
    n_chk++; if (ova !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", ova); end
    n_chk++; if (cxa !== 21'h0) begin n_fail++; $display("FAIL rst_code got %h want 0", cxa); end
    n_chk++; if (cnta !== 16'h0) begin n_fail++; $display("FAIL rst_cnt got %h want 0", cnta); end
    n_chk++; if (r0a !== 1'b0 || r0b !== 1'b0) begin
      n_fail++; $display("FAIL rst_ready got %b%b want 00", r0a, r0b);
    end
    step();
    step();
    n_chk++; if (ova !== 1'b0 || ovb !== 1'b0) begin
      n_fail++; $display("FAIL rst_hold_valid got %b%b want 00", ova, ovb);
    end
    rst_n = 1'b1;
    v0 = 1'b0;
  endtask

  task automatic test_single();
    v0 = 1'b1; d0 = 15'h0000; out_ready = 1'b1;
    #1;
    n_chk++; if (r0a !== 1'b1 || r1a !== 1'b0) begin
      n_fail++; $display("FAIL single_ready got %b%b want 10", r0a, r1a);
    end
    step();
    v0 = 1'b0;
    n_chk++; if (ova !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", ova); end
    n_chk++; if (cxa !== model(15'h0000)) begin
      n_fail++; $display("FAIL single_code got %h want %h", cxa, model(15'h0000));
    end
    n_chk++; if (srca !== 1'b0) begin n_fail++; $display("FAIL single_src got %b want 0", srca); end
    n_chk++; if (cnta !== 16'd0) begin n_fail++; $display("FAIL single_cnt0 got %0d want 0", cnta); end
    step();
    n_chk++; if (cnta !== 16'd1) begin n_fail++; $display("FAIL single_cnt1 got %0d want 1", cnta); end
    n_chk++; if (ova !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", ova); end
  endtask

  task automatic test_drain();
    v1 = 1'b1; d1 = 15'h2aaa;
    #1;
    n_chk++; if (r1a !== 1'b1 || r0a !== 1'b0) begin
      n_fail++; $display("FAIL drain_ready got %b%b want 01", r0a, r1a);
    end
    step();
    v1 = 1'b0;
    n_chk++; if (cxa !== model(15'h2aaa) || cxb !== model(15'h2aaa)) begin
      n_fail++; $display("FAIL drain_load got %h/%h want %h", cxa, cxb, model(15'h2aaa));
    end
    n_chk++; if (srca !== 1'b1) begin n_fail++; $display("FAIL drain_src got %b want 1", srca); end
    step();
    n_chk++; if (ova !== 1'b0 || ovb !== 1'b0) begin
      n_fail++; $display("FAIL drain_valid got %b%b want 00", ova, ovb);
    end
    n_chk++; if (cxa !== model(15'h2aaa)) begin
      n_fail++; $display("FAIL drain_hold got %h want %h", cxa, model(15'h2aaa));
    end
    n_chk++; if (cxb !== 21'h0) begin n_fail++; $display("FAIL drain_clear got %h want 0", cxb); end
    n_chk++; if (srca !== 1'b1) begin n_fail++; $display("FAIL drain_src_hold got %b want 1", srca); end
    n_chk++; if (cnta !== 16'd2) begin n_fail++; $display("FAIL drain_cnt got %0d want 2", cnta); end
  endtask

  task automatic test_contention();
    logic exp_src;
    v0 = 1'b1; v1 = 1'b1; d0 = 15'h1234; d1 = 15'h5678; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_src = (i % 2 == 1);
      #1;
      n_chk++; if (r0a !== !exp_src || r1a !== exp_src) begin
        n_fail++; $display("FAIL cont_ready[%0d] got %b%b want %b%b", i, r0a, r1a, !exp_src, exp_src);
      end
      step();
      n_chk++; if (ova !== 1'b1) begin n_fail++; $display("FAIL cont_valid[%0d] got %b want 1", i, ova); end
      n_chk++; if (srca !== exp_src) begin
        n_fail++; $display("FAIL cont_src[%0d] got %b want %b", i, srca, exp_src);
      end
      n_chk++; if (cxa !== model(exp_src ? 15'h5678 : 15'h1234)) begin
        n_fail++; $display("FAIL cont_code[%0d] got %h want %h", i, cxa,
                           model(exp_src ? 15'h5678 : 15'h1234));
      end
    end
    v0 = 1'b0; v1 = 1'b0;
    n_chk++; if (cnta !== 16'd5) begin n_fail++; $display("FAIL cont_cnt3 got %0d want 5", cnta); end
    step();
    n_chk++; if (cnta !== 16'd6 || cntb !== 4'd6) begin
      n_fail++; $display("FAIL cont_cnt4 got %0d/%0d want 6", cnta, cntb);
    end
    n_chk++; if (ova !== 1'b0) begin n_fail++; $display("FAIL cont_drain got %b want 0", ova); end
  endtask

  task automatic test_backpressure();
    v0 = 1'b1; d0 = 15'h0f0f; out_ready = 1'b1;
    step();
    out_ready = 1'b0; d0 = 15'h7001; v1 = 1'b1; d1 = 15'h1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++; if (r0a !== 1'b0 || r1a !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready[%0d] got %b%b want 00", i, r0a, r1a);
      end
      step();
      n_chk++; if (ova !== 1'b1 || cxa !== model(15'h0f0f) || srca !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d] got %b %h %b want 1 %h 0", i, ova, cxa, srca,
                           model(15'h0f0f));
      end
      n_chk++; if (cnta !== 16'd6) begin
        n_fail++; $display("FAIL bp_cnt[%0d] got %0d want 6", i, cnta);
      end
    end
    out_ready = 1'b1;
    #1;
    n_chk++; if (r0a !== 1'b0 || r1a !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready got %b%b want 01", r0a, r1a);
    end
    step();
    v0 = 1'b0; v1 = 1'b0;
    n_chk++; if (ova !== 1'b1 || cxa !== model(15'h1111) || srca !== 1'b1) begin
      n_fail++; $display("FAIL bp_load got %b %h %b want 1 %h 1", ova, cxa, srca, model(15'h1111));
    end
    n_chk++; if (cnta !== 16'd7) begin n_fail++; $display("FAIL bp_cnt7 got %0d want 7", cnta); end
    step();
    n_chk++; if (cnta !== 16'd8 || ova !== 1'b0) begin
      n_fail++; $display("FAIL bp_final got %0d %b want 8 0", cnta, ova);
    end
  endtask

  task automatic test_saturation();
    v0 = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d0 = 15'(i * 977);
      step();
    end
    v0 = 1'b0;
    n_chk++; if (cnta !== 16'd27) begin n_fail++; $display("FAIL sat_cnta got %0d want 27", cnta); end
    n_chk++; if (cntb !== 4'hF) begin n_fail++; $display("FAIL sat_cntb got %h want f", cntb); end
    step();
    step();
    n_chk++; if (cnta !== 16'd28) begin n_fail++; $display("FAIL sat_cnta2 got %0d want 28", cnta); end
    n_chk++; if (cntb !== 4'hF) begin n_fail++; $display("FAIL sat_stay got %h want f", cntb); end
  endtask

  task automatic test_reset_mid();
    v0 = 1'b1; d0 = 15'h0555; out_ready = 1'b0;
    step();
    v0 = 1'b0;
    n_chk++; if (ova !== 1'b1) begin n_fail++; $display("FAIL mid_full got %b want 1", ova); end
    #2;
    rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    #1;
    n_chk++; if (ova !== 1'b0 || cxa !== 21'h0 || srca !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_out got %b %h %b want 0 0 0", ova, cxa, srca);
    end
    n_chk++; if (cnta !== 16'h0 || cntb !== 4'h0) begin
      n_fail++; $display("FAIL mid_rst_cnt got %0d/%0d want 0", cnta, cntb);
    end
    n_chk++; if (r0a !== 1'b0 || r1a !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_ready got %b%b want 00", r0a, r1a);
    end
    step();
    rst_n = 1'b1;
    d0 = 15'h3c3c; d1 = 15'h4242; out_ready = 1'b1;
    #1;
    n_chk++; if (r0a !== 1'b1 || r1a !== 1'b0) begin
      n_fail++; $display("FAIL mid_ptr got %b%b want 10", r0a, r1a);
    end
    step();
    v0 = 1'b0; v1 = 1'b0;
    n_chk++; if (srca !== 1'b0 || cxa !== model(15'h3c3c)) begin
      n_fail++; $display("FAIL mid_first got %b %h want 0 %h", srca, cxa, model(15'h3c3c));
    end
    step();
    n_chk++; if (cnta !== 16'd1) begin n_fail++; $display("FAIL mid_cnt got %0d want 1", cnta); end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_drain();
    test_contention();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
